// File: rtl/stream_mux_n1.sv
// rtl/stream_mux_n1.sv - N:1 valid/ready stream mux with packet lock and registered output
//
// Selects one of CHANNELS producer streams by fixed index (i_SEL) or round-robin
// (i_RR_EN=1). Once a packet has started, the mux stays on its channel until that
// packet's last beat. The output is a single registered beat.
//
// Ports:
//   i_CLK, i_RST_N      clock, synchronous active-low reset
//   i_DATA              channel k data at [k*WIDTH +: WIDTH]
//   i_VALID, i_LAST     per-channel beat valid / end-of-packet
//   o_READY             per-channel ready (one-hot or zero)
//   i_SEL, i_RR_EN      channel index for select mode / round-robin enable
//   o_DATA, o_LAST      output beat data / end-of-packet
//   o_CH                source channel of the output beat
//   o_VALID, i_READY    output handshake
module stream_mux_n1 #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      i_CLK,
    input  logic                      i_RST_N,
    input  logic [CHANNELS*WIDTH-1:0] i_DATA,
    input  logic [CHANNELS-1:0]       i_VALID,
    input  logic [CHANNELS-1:0]       i_LAST,
    output logic [CHANNELS-1:0]       o_READY,
    input  logic [SEL_W-1:0]          i_SEL,
    input  logic                      i_RR_EN,
    output logic [WIDTH-1:0]          o_DATA,
    output logic                      o_LAST,
    output logic [SEL_W-1:0]          o_CH,
    output logic                      o_VALID,
    input  logic                      i_READY
);

    // One extra bit so channel arithmetic never overflows for non-power-of-2 counts.
    localparam logic [SEL_W:0] CH_COUNT = (SEL_W+1)'(CHANNELS);
    localparam logic [SEL_W:0] CH_LAST  = CH_COUNT - (SEL_W+1)'(1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_t;

    lock_state_t         state;
    lock_state_t         state_next;
    logic [SEL_W-1:0]    lock_ch;
    logic [SEL_W-1:0]    lock_ch_next;
    logic [SEL_W-1:0]    rr_ptr;

    logic                grant_vld;
    logic [SEL_W-1:0]    grant_ch;
    logic [SEL_W:0]      cand;
    logic [CHANNELS-1:0] grant_oh;
    logic                can_load;
    logic                xfer;
    logic                xfer_last;
    logic [WIDTH-1:0]    xfer_data;

    assign can_load  = ~o_VALID | i_READY;
    assign grant_oh  = grant_vld ? (CHANNELS'(1) << grant_ch) : '0;
    assign o_READY   = (i_RST_N & can_load) ? grant_oh : '0;
    assign xfer      = |(i_VALID & o_READY);
    assign xfer_last = i_LAST[grant_ch];
    assign xfer_data = i_DATA[int'(grant_ch) * WIDTH +: WIDTH];

    // Lock state, locked channel and round-robin pointer.
    always_ff @(posedge i_CLK) begin
        if (!i_RST_N) begin
            state   <= ST_IDLE;
            lock_ch <= '0;
            rr_ptr  <= '0;
        end else begin
            state   <= state_next;
            lock_ch <= lock_ch_next;
            // Pointer advances past the channel that just finished a packet.
            if (xfer && xfer_last) begin
                rr_ptr <= ({1'b0, grant_ch} == CH_LAST) ? '0 : grant_ch + SEL_W'(1);
            end
        end
    end

    // Next-state: a non-last beat opens (or continues) a lock, a last beat releases it.
    always_comb begin
        state_next   = state;
        lock_ch_next = lock_ch;
        if (xfer) begin
            if (xfer_last) begin
                state_next = ST_IDLE;
            end else begin
                state_next   = ST_LOCKED;
                lock_ch_next = grant_ch;
            end
        end
    end

    // Grant: locked channel wins; otherwise fixed select or round-robin search.
    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = '0;
        cand      = '0;
        if (state == ST_LOCKED) begin
            grant_vld = 1'b1;
            grant_ch  = lock_ch;
        end else if (!i_RR_EN) begin
            if ({1'b0, i_SEL} < CH_COUNT) begin
                grant_vld = 1'b1;
                grant_ch  = i_SEL;
            end
        end else begin
            // Walk offsets from far to near so the nearest valid channel after
            // rr_ptr is the one left standing.
            for (int i = CHANNELS - 1; i >= 0; i--) begin
                cand = {1'b0, rr_ptr} + (SEL_W+1)'(i);
                if (cand >= CH_COUNT) begin
                    cand = cand - CH_COUNT;
                end
                if (i_VALID[cand[SEL_W-1:0]]) begin
                    grant_vld = 1'b1;
                    grant_ch  = cand[SEL_W-1:0];
                end
            end
        end
    end

    // Output beat register; payload holds when nothing new is loaded.
    always_ff @(posedge i_CLK) begin
        if (!i_RST_N) begin
            o_VALID <= 1'b0;
            o_DATA  <= '0;
            o_LAST  <= 1'b0;
            o_CH    <= '0;
        end else if (xfer) begin
            o_VALID <= 1'b1;
            o_DATA  <= xfer_data;
            o_LAST  <= xfer_last;
            o_CH    <= grant_ch;
        end else if (i_READY) begin
            o_VALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_mux_n1.sv
// tb/tb_stream_mux_n1.sv - scoreboard bench for stream_mux_n1
module tb_stream_mux_n1;

    localparam int CH = 4;
    localparam int W  = 8;
    localparam int SW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [CH*W-1:0] i_data;
    logic [CH-1:0]   i_valid;
    logic [CH-1:0]   i_last;
    logic [CH-1:0]   o_ready;
    logic [SW-1:0]   i_sel;
    logic            i_rr_en;
    logic [W-1:0]    o_data;
    logic            o_last;
    logic [SW-1:0]   o_ch;
    logic            o_valid;
    logic            i_ready;

    stream_mux_n1 #(.CHANNELS(CH), .WIDTH(W), .SEL_W(SW)) dut (
        .i_CLK   (clk),
        .i_RST_N (rst_n),
        .i_DATA  (i_data),
        .i_VALID (i_valid),
        .i_LAST  (i_last),
        .o_READY (o_ready),
        .i_SEL   (i_sel),
        .i_RR_EN (i_rr_en),
        .o_DATA  (o_data),
        .o_LAST  (o_last),
        .o_CH    (o_ch),
        .o_VALID (o_valid),
        .i_READY (i_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           ch;
        logic [W-1:0] data;
        logic         last;
    } exp_t;

    exp_t          exp_q[$];
    logic [W:0]    prod_q[CH][$];
    logic [CH-1:0] hs_vec = '0;
    logic          gap_en = 1'b0;
    logic          exp_zero = 1'b0;
    int            m_lock = -1;
    int            m_rr = 0;
    int            n_checks = 0;
    int            n_pass = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    endfunction

    task automatic drive_inputs();
        for (int k = 0; k < CH; k++) begin
            if (prod_q[k].size() > 0 && !(gap_en && $urandom_range(0, 3) == 0)) begin
                i_valid[k]        = 1'b1;
                i_data[k*W +: W]  = prod_q[k][0][W-1:0];
                i_last[k]         = prod_q[k][0][W];
            end else begin
                i_valid[k]        = 1'b0;
                i_data[k*W +: W]  = 8'($urandom);
                i_last[k]         = 1'($urandom);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int k = 0; k < CH; k++) begin
            if (hs_vec[k] && prod_q[k].size() > 0) void'(prod_q[k].pop_front());
        end
        drive_inputs();
    endtask

    task automatic send(int ch, int n, logic [W-1:0] base);
        for (int j = 0; j < n; j++) begin
            logic [W-1:0] d;
            d = base + W'(j);
            prod_q[ch].push_back({(j == n - 1), d});
        end
        drive_inputs();
    endtask

    task automatic do_reset(int cycles);
        rst_n = 1'b0;
        repeat (cycles) step();
        rst_n = 1'b1;
    endtask

    // Reference model: decides grants and transfers from the mux rules and
    // pushes each accepted beat as the expected next output.
    always @(negedge clk) begin
        int           g;
        bit           can_load;
        logic [CH-1:0] exp_rdy;
        #1;
        hs_vec = i_valid & o_ready;
        if (!rst_n) begin
            exp_q.delete();
            m_lock   = -1;
            m_rr     = 0;
            exp_zero = 1'b1;
            chk("ready_in_reset", 32'(o_ready), 32'd0);
        end else begin
            if (m_lock >= 0) g = m_lock;
            else if (!i_rr_en) g = (int'(i_sel) < CH) ? int'(i_sel) : -1;
            else begin
                g = -1;
                for (int j = 0; j < CH; j++) begin
                    int c;
                    c = (m_rr + j) % CH;
                    if (i_valid[c]) begin
                        g = c;
                        break;
                    end
                end
            end
            can_load = (exp_q.size() == 0) || i_ready;
            exp_rdy  = (g >= 0 && can_load) ? CH'(1 << g) : '0;
            chk("o_ready", 32'(o_ready), 32'(exp_rdy));
            if (g >= 0 && can_load && i_valid[g]) begin
                exp_t e;
                e.ch   = g;
                e.data = i_data[g*W +: W];
                e.last = i_last[g];
                exp_q.push_back(e);
                if (e.last) begin
                    m_lock = -1;
                    m_rr   = (g + 1) % CH;
                end else begin
                    m_lock = g;
                end
            end
        end
    end

    // Monitor: compares each presented output beat with the scoreboard head.
    always @(negedge clk) begin
        if (exp_zero) begin
            chk("rst_valid", 32'(o_valid), 32'd0);
            chk("rst_data",  32'(o_data),  32'd0);
            chk("rst_last",  32'(o_last),  32'd0);
            chk("rst_ch",    32'(o_ch),    32'd0);
            exp_zero = 1'b0;
        end else begin
            chk("o_valid", 32'(o_valid), 32'(exp_q.size() != 0));
            if (o_valid && exp_q.size() != 0) begin
                chk("o_ch",   32'(o_ch),   32'(exp_q[0].ch));
                chk("o_data", 32'(o_data), 32'(exp_q[0].data));
                chk("o_last", 32'(o_last), 32'(exp_q[0].last));
                if (i_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        int left;
        rst_n   = 1'b0;
        i_sel   = '0;
        i_rr_en = 1'b0;
        i_ready = 1'b1;
        i_valid = '0;
        i_data  = '0;
        i_last  = '0;
        repeat (2) step();
        rst_n = 1'b1;

        // single beat on selected channel 2
        i_sel = 2'd2;
        send(2, 1, 8'hA5);
        repeat (3) step();

        // backpressure on a 3-beat ch0 stream
        i_sel = 2'd0;
        send(0, 3, 8'h10);
        step();
        i_ready = 1'b0;
        repeat (3) step();
        i_ready = 1'b1;
        repeat (4) step();

        // packet lock survives a select change
        i_sel = 2'd1;
        send(1, 3, 8'h20);
        send(3, 2, 8'h30);
        step();
        i_sel = 2'd3;
        repeat (7) step();

        // round-robin with wrap
        do_reset(1);
        i_rr_en = 1'b1;
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < CH; k++) send(k, 1, 8'(8'h40 + r * 4 + k));
        repeat (10) step();

        // round-robin skip starting from rr_ptr=2
        do_reset(1);
        i_rr_en = 1'b0;
        i_sel   = 2'd1;
        send(1, 1, 8'h50);
        repeat (2) step();
        i_rr_en = 1'b1;
        send(1, 1, 8'h51);
        send(1, 1, 8'h52);
        send(3, 1, 8'h53);
        send(3, 1, 8'h54);
        repeat (7) step();

        // reset during a 4-beat packet
        i_rr_en = 1'b0;
        i_sel   = 2'd0;
        send(0, 4, 8'h60);
        step();
        do_reset(1);
        repeat (6) step();

        // randomized traffic
        gap_en = 1'b1;
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 39) == 0) i_rr_en = ~i_rr_en;
            if ($urandom_range(0, 9) == 0)  i_sel = 2'($urandom);
            i_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) begin
                int ch;
                ch = $urandom_range(0, CH - 1);
                if (prod_q[ch].size() < 8) send(ch, $urandom_range(1, 4), 8'($urandom));
            end
            if ($urandom_range(0, 299) == 0) do_reset(1);
            else step();
        end

        // drain everything in round-robin
        gap_en  = 1'b0;
        i_rr_en = 1'b1;
        i_ready = 1'b1;
        for (int c = 0; c < 400; c++) begin
            left = exp_q.size();
            for (int k = 0; k < CH; k++) left += prod_q[k].size();
            if (left == 0) break;
            step();
        end
        repeat (2) step();
        left = exp_q.size();
        for (int k = 0; k < CH; k++) left += prod_q[k].size();
        chk("drain_left", 32'(left), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
